// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - oversampling 8N1 UART receiver with a one-deep valid/ready output register
// Define UART_RX_PARITY_EN for 8E1: an even-parity bit is checked between bit 7 and the stop bit.
module uart_rx_byte #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rxd,
  output logic [7:0] dat_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd4;
`endif

  logic          rx_meta_q, rxs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dat_q, dat_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          par_ok;
  logic          tick;

`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    dat_d   = dat_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (valid_q && ready_i) valid_d = 1'b0;

    case (state_q)
      S_WAIT_IDLE: begin
        if (rxs_q) begin
          state_d = S_IDLE;
          cnt_d   = BIT_LOAD;
        end
      end
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        // Start bit must still be low at its centre, otherwise it was a glitch.
        if (tick) begin
          cnt_d = BIT_LOAD;
          if (!rxs_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_d   = rxs_q;
          cnt_d   = BIT_LOAD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_d = BIT_LOAD;
          if (rxs_q && par_ok) begin
            state_d = S_IDLE;
            // A same-cycle handshake frees the holding register for the new byte.
            if (!valid_q || ready_i) begin
              dat_d   = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      default: begin
        state_d = S_WAIT_IDLE;
        cnt_d   = BIT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_WAIT_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      dat_q     <= 8'd0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= uart_rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dat_q     <= dat_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign dat_o       = dat_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != S_WAIT_IDLE) && (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed table-driven bench for uart_rx_byte at 10 clocks per bit
// Frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       uart_rxd;
  logic       ready_i;
  logic [7:0] dat_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  int acc_n  = 0;
  int vhi_n  = 0;
  int ferr_n = 0;
  int ovr_n  = 0;
  int both_n = 0;
  logic [7:0] acc_byte = 8'd0;

  int acc0, vhi0, ferr0, ovr0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_byte #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .uart_rxd   (uart_rxd),
    .dat_o      (dat_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Output event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_o) vhi_n <= vhi_n + 1;
    if (valid_o && ready_i) begin
      acc_n    <= acc_n + 1;
      acc_byte <= dat_o;
    end
    if (frame_err_o) ferr_n <= ferr_n + 1;
    if (overrun_o) ovr_n <= ovr_n + 1;
    if (frame_err_o && overrun_o) both_n <= both_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic snap();
    acc0  = acc_n;
    vhi0  = vhi_n;
    ferr0 = ferr_n;
    ovr0  = ovr_n;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    uart_rxd = 1'b1;
    tick(2 * CPB);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ par_flip;
    tick(CPB);
`else
    if (par_flip) uart_rxd = 1'b1;
`endif
    uart_rxd = stop;
    tick(CPB);
  endtask

  task automatic finish_frame();
    uart_rxd = 1'b1;
    tick(CPB);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hA3, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b0};

    rst_i    = 1'b1;
    uart_rxd = 1'b1;
    ready_i  = 1'b1;
    tick(3);
    check("rst_dat", 32'(dat_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_ferr", 32'(frame_err_o), 32'h0);
    check("rst_ovr", 32'(overrun_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    rst_i = 1'b0;
    tick(5);

    for (int v = 0; v < 7; v++) begin
      snap();
      send_frame(vecs[v].d, vecs[v].stop, 1'b0);
      finish_frame();
      check($sformatf("vec%0d_acc", v), 32'(acc_n - acc0), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_vhi", v), 32'(vhi_n - vhi0), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_ferr", v), 32'(ferr_n - ferr0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_n - ovr0), 32'h0);
      if (vecs[v].exp_valid) check($sformatf("vec%0d_byte", v), 32'(acc_byte), 32'(vecs[v].d));
    end

    // Short low glitch on an idle line.
    snap();
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(2);
    check("glitch_busy_mid", 32'(busy_o), 32'h1);
    tick(20);
    check("glitch_busy_end", 32'(busy_o), 32'h0);
    check("glitch_vhi", 32'(vhi_n - vhi0), 32'h0);
    check("glitch_ferr", 32'(ferr_n - ferr0), 32'h0);

    // Bad stop bit, line held low, then a good frame.
    snap();
    send_frame(8'hA3, 1'b0, 1'b0);
    uart_rxd = 1'b0;
    tick(30);
    check("ferr_pulse", 32'(ferr_n - ferr0), 32'h1);
    check("ferr_novalid", 32'(vhi_n - vhi0), 32'h0);
    send_frame(8'h01, 1'b1, 1'b0);
    finish_frame();
    check("ferr_recover_acc", 32'(acc_n - acc0), 32'h1);
    check("ferr_recover_byte", 32'(acc_byte), 32'h01);
    check("ferr_no_extra", 32'(ferr_n - ferr0), 32'h1);

    // Overrun with the consumer stalled.
    ready_i = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    finish_frame();
    check("ovr_first_valid", 32'(valid_o), 32'h1);
    check("ovr_first_dat", 32'(dat_o), 32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    finish_frame();
    check("ovr_pulse", 32'(ovr_n - ovr0), 32'h1);
    check("ovr_dat_kept", 32'(dat_o), 32'h11);
    check("ovr_valid_kept", 32'(valid_o), 32'h1);
    check("ovr_noferr", 32'(ferr_n - ferr0), 32'h0);
    ready_i = 1'b1;
    tick(2);
    check("ovr_drain_acc", 32'(acc_n - acc0), 32'h1);
    check("ovr_drain_byte", 32'(acc_byte), 32'h11);
    check("ovr_drain_valid", 32'(valid_o), 32'h0);

    // Reset mid-frame discards both the held byte and the partial one.
    ready_i = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    finish_frame();
    check("rstmid_held", 32'(valid_o), 32'h1);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = (i == 0) ? 1'b0 : 1'b1;
      tick(CPB);
    end
    uart_rxd = 1'b1;
    tick(5);
    check("rstmid_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check("rstmid_valid", 32'(valid_o), 32'h0);
    check("rstmid_dat", 32'(dat_o), 32'h0);
    check("rstmid_busy_clr", 32'(busy_o), 32'h0);
    ready_i = 1'b1;
    snap();
    tick(20 * CPB);
    check("rstmid_nobyte", 32'(acc_n - acc0), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b0);
    finish_frame();
    check("rstmid_next_acc", 32'(acc_n - acc0), 32'h1);
    check("rstmid_next_byte", 32'(acc_byte), 32'h3C);
    check("rstmid_next_ferr", 32'(ferr_n - ferr0), 32'h0);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h03, 1'b1, 1'b0);
    finish_frame();
    check("par_ok_acc", 32'(acc_n - acc0), 32'h1);
    check("par_ok_byte", 32'(acc_byte), 32'h03);
    snap();
    send_frame(8'h03, 1'b1, 1'b1);
    finish_frame();
    check("par_bad_ferr", 32'(ferr_n - ferr0), 32'h1);
    check("par_bad_acc", 32'(acc_n - acc0), 32'h0);
`endif

    check("ferr_ovr_exclusive", 32'(both_n), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
